// File: rtl/i2c_target_regif.sv
// i2c_target_regif: I2C target controller for the colour-sensor register file.
// Oversamples the open-drain bus with clk, decodes START/STOP, address, register
// pointer and data bytes, and turns bus transfers into single-cycle register
// read/write strobes. SDA is only ever pulled low (ACK and read-data 0 bits).
//
// Parameters:
//   TARGET_ADDR  7-bit bus address answered to (general call 0 never ACKed)
//   HOLD_CYC     clk cycles after internal SCL fall before SDA drive changes;
//                must be >= 3 so the first read bit follows the rdata capture
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   scl_i, sda_i resolved bus levels
//   sda_oe       1 pulls SDA low, 0 releases
//   reg_addr     register pointer
//   reg_wdata    write data, valid with reg_we
//   reg_we       one-cycle write strobe
//   reg_re       one-cycle read strobe; reg_rdata captured the following cycle
//   reg_rdata    read data from the register file
//   busy         high from START until STOP
// Build option:
//   I2C_TARGET_GLITCH_FILTER_EN  adds a 3-sample majority filter per input,
//                                rejecting 1-cycle pulses (4-cycle input latency)

module i2c_target_regif #(
    parameter logic [6:0]  TARGET_ADDR = 7'h29,
    parameter int unsigned HOLD_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } state_t;

    // Two-flop synchronizers; reset to the idle (pulled-up) bus level.
    logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
        end
    end

    logic w_scl, w_sda;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // Majority of the current synchronized sample and the two before it.
    logic [1:0] r_scl_hist, r_sda_hist;
    logic       r_scl_f, r_sda_f;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_s2};
            r_sda_hist <= {r_sda_hist[0], r_sda_s2};
            r_scl_f    <= maj3({r_scl_hist, r_scl_s2});
            r_sda_f    <= maj3({r_sda_hist, r_sda_s2});
        end
    end

    assign w_scl = r_scl_f;
    assign w_sda = r_sda_f;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    // Previous internal levels for edge detection.
    logic r_scl_d, r_sda_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    // START/STOP only need SCL high now, so an SDA change coinciding with an
    // SCL rise is a bus condition rather than a data bit.
    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & ~r_sda_d & w_sda;

    state_t           r_state;
    logic [2:0]       r_bit_cnt;
    logic [6:0]       r_shift;
    logic             r_rw;
    logic             r_ack_rise;
    logic             r_re_d;
    logic [7:0]       r_tx;
    logic [CNT_W-1:0] r_hold_cnt;

    logic [7:0] w_byte;
    logic       w_oe_target;

    assign w_byte = {r_shift, w_sda};

    // SDA drive level for the current SCL-low phase.
    always_comb begin
        w_oe_target = 1'b0;
        case (r_state)
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: w_oe_target = 1'b1;
            S_RDATA:                            w_oe_target = ~r_tx[3'(3'd7 - r_bit_cnt)];
            default:                            w_oe_target = 1'b0;
        endcase
    end

    // Main controller: bus FSM, strobes, pointer and delayed SDA drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_rw       <= 1'b0;
            r_ack_rise <= 1'b0;
            r_re_d     <= 1'b0;
            r_tx       <= 8'd0;
            r_hold_cnt <= '0;
            sda_oe     <= 1'b0;
            reg_addr   <= 8'd0;
            reg_wdata  <= 8'd0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            r_re_d <= reg_re;
            if (r_re_d) begin
                r_tx <= reg_rdata;
            end
            // Post-write pointer increment, one cycle after the strobe.
            if (reg_we) begin
                reg_addr <= reg_addr + 8'd1;
            end
            // SDA only changes once the hold window after SCL fall has expired.
            if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - CNT_W'(1);
                if (r_hold_cnt == CNT_W'(1)) begin
                    sda_oe <= w_oe_target;
                end
            end

            if (w_stop) begin
                r_state    <= S_IDLE;
                busy       <= 1'b0;
                sda_oe     <= 1'b0;
                r_hold_cnt <= '0;
            end else if (w_start) begin
                r_state    <= S_ADDR;
                busy       <= 1'b1;
                sda_oe     <= 1'b0;
                r_hold_cnt <= '0;
                r_bit_cnt  <= 3'd0;
            end else begin
                if (w_scl_fall) begin
                    r_hold_cnt <= CNT_W'(HOLD_CYC);
                end
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
                                if ((r_shift == TARGET_ADDR) && (TARGET_ADDR != 7'd0)) begin
                                    r_rw       <= w_sda;
                                    r_ack_rise <= 1'b0;
                                    r_state    <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        // Leave on the fall that ends the ACK bit, not the 8th-bit fall.
                        if (w_scl_rise) begin
                            r_ack_rise <= 1'b1;
                        end
                        if (w_scl_fall && r_ack_rise) begin
                            r_bit_cnt <= 3'd0;
                            if (r_rw) begin
                                reg_re  <= 1'b1;
                                r_state <= S_RDATA;
                            end else begin
                                r_state <= S_PTR;
                            end
                        end
                    end
                    S_PTR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt  <= 3'd0;
                                reg_addr   <= w_byte;
                                r_ack_rise <= 1'b0;
                                r_state    <= S_PTR_ACK;
                            end
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_rise) begin
                            r_ack_rise <= 1'b1;
                        end
                        if (w_scl_fall && r_ack_rise) begin
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt  <= 3'd0;
                                reg_wdata  <= w_byte;
                                reg_we     <= 1'b1;
                                r_ack_rise <= 1'b0;
                                r_state    <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt  <= 3'd0;
                                r_ack_rise <= 1'b0;
                                r_state    <= S_RDATA_ACK;
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        // Pointer advances at the ACK rise so the next read sees it.
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                reg_addr   <= reg_addr + 8'd1;
                                r_ack_rise <= 1'b1;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                        if (w_scl_fall && r_ack_rise) begin
                            reg_re    <= 1'b1;
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_RDATA;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regif.sv
// Bench for i2c_target_regif: a bus master drives SCL/SDA, a register-file
// model answers reads, and scoreboard queues compare expected vs observed
// strobes and read bytes.
module tb_i2c_target_regif;

    localparam int unsigned Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl, m_sda;
    logic       scl_w, sda_w;
    logic       sda_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    always #5 clk = ~clk;

    assign scl_w = m_scl;
    assign sda_w = m_sda & ~sda_oe;

    i2c_target_regif #(.TARGET_ADDR(7'h29), .HOLD_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_w),
        .sda_i     (sda_w),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic [7:0] mem [256];
    wr_t        exp_wr_q[$];
    wr_t        obs_wr_q[$];
    logic [7:0] exp_re_q[$];
    logic [7:0] obs_re_q[$];
    logic [7:0] exp_rd_q[$];

    int   n_pass = 0;
    int   n_total = 0;
    int   we_long = 0;
    int   scl_high_changes = 0;
    int   busy_rises = 0;
    logic any_oe = 1'b0;
    logic prev_we = 1'b0;
    logic prev_oe = 1'b0;
    logic prev_busy = 1'b0;

    // Register file read port: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (reg_re === 1'b1) reg_rdata <= mem[reg_addr];
    end

    // Monitor on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (reg_we === 1'b1) obs_wr_q.push_back({reg_addr, reg_wdata});
        if (reg_re === 1'b1) obs_re_q.push_back(reg_addr);
        if (reg_we === 1'b1 && prev_we === 1'b1) we_long++;
        if (rst === 1'b0 && sda_oe !== prev_oe && m_scl === 1'b1) scl_high_changes++;
        if (sda_oe === 1'b1) any_oe = 1'b1;
        if (busy === 1'b1 && prev_busy !== 1'b1) busy_rises++;
        prev_we   = reg_we;
        prev_oe   = sda_oe;
        prev_busy = busy;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        tick(2);
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        tick(2);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        tick(2);
        m_sda = b;
        tick(Q - 2);
        m_scl = 1'b1;
        tick(Q);
        r = sda_w;
        tick(Q);
        m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
        xfer_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            xfer_bit(1'b1, r);
            d = {d[6:0], r};
        end
        xfer_bit(~mack, r);
    endtask

    task automatic clear_obs();
        obs_wr_q.delete();
        obs_re_q.delete();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(4);
        n_total++;
        if ({sda_oe, reg_we, reg_re, busy} !== 4'b0000)
            $display("FAIL reset_ctrl: got oe/we/re/busy=%b want 0000", {sda_oe, reg_we, reg_re, busy});
        else n_pass++;
        rst = 1'b0;
        tick(3);
        n_total++;
        if (reg_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", reg_addr);
        else n_pass++;
        n_total++;
        if (reg_wdata !== 8'h00) $display("FAIL reset_wdata: got %h want 00", reg_wdata);
        else n_pass++;
        n_total++;
        if ({sda_oe, busy} !== 2'b00) $display("FAIL reset_idle: got oe/busy=%b want 00", {sda_oe, busy});
        else n_pass++;
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        wr_t  e, o;
        clear_obs();
        we_long = 0;
        exp_wr_q.push_back({8'h10, 8'hA5});
        exp_wr_q.push_back({8'h11, 8'h3C});
        bus_start();
        send_byte(8'h52, a0);
        send_byte(8'h10, a1);
        send_byte(8'hA5, a2);
        send_byte(8'h3C, a3);
        n_total++;
        if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL write_acks: got %b want 0000", {a0, a1, a2, a3});
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL write_busy_before_stop: got %b want 1", busy);
        else n_pass++;
        bus_stop();
        n_total++;
        if (busy !== 1'b0) $display("FAIL write_busy_after_stop: got %b want 0", busy);
        else n_pass++;
        while (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            n_total++;
            if (obs_wr_q.size() == 0) $display("FAIL write_strobe: got none want addr %h data %h", e.addr, e.data);
            else begin
                o = obs_wr_q.pop_front();
                if (o !== e) $display("FAIL write_strobe: got addr %h data %h want addr %h data %h", o.addr, o.data, e.addr, e.data);
                else n_pass++;
            end
        end
        n_total++;
        if (obs_wr_q.size() != 0) $display("FAIL write_extra: got %0d extra strobes want 0", obs_wr_q.size());
        else n_pass++;
        n_total++;
        if (we_long != 0) $display("FAIL write_we_width: got %0d long pulses want 0", we_long);
        else n_pass++;
    endtask

    task automatic test_read();
        logic       a0, a1, a2;
        logic [7:0] b, e, o;
        logic [7:0] obs_rd_q[$];
        clear_obs();
        mem[8'h80] = 8'hC3;
        mem[8'h81] = 8'h5A;
        exp_re_q.push_back(8'h80);
        exp_re_q.push_back(8'h81);
        exp_rd_q.push_back(8'hC3);
        exp_rd_q.push_back(8'h5A);
        bus_start();
        send_byte(8'h52, a0);
        send_byte(8'h80, a1);
        bus_start();
        send_byte(8'h53, a2);
        n_total++;
        if ({a0, a1, a2} !== 3'b000) $display("FAIL read_acks: got %b want 000", {a0, a1, a2});
        else n_pass++;
        read_byte(1'b1, b);
        obs_rd_q.push_back(b);
        read_byte(1'b0, b);
        obs_rd_q.push_back(b);
        tick(Q);
        n_total++;
        if (sda_oe !== 1'b0) $display("FAIL read_release_after_nack: got %b want 0", sda_oe);
        else n_pass++;
        while (exp_rd_q.size() > 0) begin
            e = exp_rd_q.pop_front();
            o = obs_rd_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL read_byte: got %h want %h", o, e);
            else n_pass++;
        end
        while (exp_re_q.size() > 0) begin
            e = exp_re_q.pop_front();
            n_total++;
            if (obs_re_q.size() == 0) $display("FAIL read_strobe: got none want addr %h", e);
            else begin
                o = obs_re_q.pop_front();
                if (o !== e) $display("FAIL read_strobe: got addr %h want %h", o, e);
                else n_pass++;
            end
        end
        n_total++;
        if (obs_re_q.size() + obs_wr_q.size() != 0)
            $display("FAIL read_extra_strobes: got %0d want 0", obs_re_q.size() + obs_wr_q.size());
        else n_pass++;
        bus_stop();
    endtask

    task automatic test_mismatch();
        logic a0, a1, a2;
        clear_obs();
        any_oe = 1'b0;
        bus_start();
        send_byte(8'h54, a0);
        send_byte(8'h10, a1);
        send_byte(8'hA5, a2);
        n_total++;
        if ({a0, a1, a2} !== 3'b111) $display("FAIL mismatch_nack: got %b want 111", {a0, a1, a2});
        else n_pass++;
        n_total++;
        if (any_oe !== 1'b0) $display("FAIL mismatch_sda_oe: got %b want 0", any_oe);
        else n_pass++;
        n_total++;
        if (obs_re_q.size() + obs_wr_q.size() != 0)
            $display("FAIL mismatch_strobes: got %0d want 0", obs_re_q.size() + obs_wr_q.size());
        else n_pass++;
        bus_stop();
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3;
        wr_t  e, o;
        clear_obs();
        exp_wr_q.push_back({8'hFF, 8'h11});
        exp_wr_q.push_back({8'h00, 8'h22});
        bus_start();
        send_byte(8'h52, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        bus_stop();
        n_total++;
        if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3});
        else n_pass++;
        while (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            n_total++;
            if (obs_wr_q.size() == 0) $display("FAIL wrap_strobe: got none want addr %h data %h", e.addr, e.data);
            else begin
                o = obs_wr_q.pop_front();
                if (o !== e) $display("FAIL wrap_strobe: got addr %h data %h want addr %h data %h", o.addr, o.data, e.addr, e.data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic a0, a1, a2, r;
        int   k;
        mem[8'h40] = 8'h00;
        bus_start();
        send_byte(8'h52, a0);
        send_byte(8'h40, a1);
        bus_start();
        send_byte(8'h53, a2);
        k = 0;
        while (sda_oe !== 1'b1 && k < 4 * Q) begin
            tick(1);
            k++;
        end
        n_total++;
        if (sda_oe !== 1'b1) $display("FAIL rstmid_drive_zero: got %b want 1 within %0d cycles", sda_oe, 4 * Q);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (sda_oe !== 1'b0) $display("FAIL rstmid_release: got %b want 0", sda_oe);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy);
        else n_pass++;
        tick(2);
        rst = 1'b0;
        clear_obs();
        any_oe = 1'b0;
        for (int i = 0; i < 9; i++) xfer_bit(1'b0, r);
        n_total++;
        if (any_oe !== 1'b0 || obs_re_q.size() + obs_wr_q.size() != 0)
            $display("FAIL rstmid_quiet: got oe=%b strobes=%0d want oe=0 strobes=0", any_oe, obs_re_q.size() + obs_wr_q.size());
        else n_pass++;
        bus_stop();
    endtask

    task automatic test_glitch();
        int exp_rises;
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(8);
        busy_rises = 0;
        m_sda = 1'b0;
        tick(1);
        m_sda = 1'b1;
        tick(12);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        exp_rises = 0;
`else
        exp_rises = 1;
`endif
        n_total++;
        if (busy_rises != exp_rises) $display("FAIL glitch_start_detect: got %0d want %0d", busy_rises, exp_rises);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL glitch_busy_final: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_sda_timing();
        n_total++;
        if (scl_high_changes != 0) $display("FAIL sda_change_scl_high: got %0d want 0", scl_high_changes);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        reg_rdata = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_wrap();
        test_reset_mid_read();
        test_glitch();
        test_sda_timing();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
